id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: DATA_W 16 instruction/register width; PC_W 8 program-counter width; REG_N 8 register count (3-bit addresses).
REQ-002 clk_ibuf  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 instruction  in  16  fetched word from the fetch stage, valid every cycle instruction_fetch_en=1.
REQ-005 pc  in  8  address of instruction.
REQ-006 ex_is_load / ex_rd  in  1 / 3  instruction currently in EX is LW, and its destination.
REQ-007 wb_en / wb_addr / wb_data  in  1 / 3 / 16  register-file write port.
REQ-008 instruction_fetch_en  out  1  fetch advance enable (0 = stall fetch).
REQ-009 branch_taken / branch_offset_imm  out  1 / 6  redirect request and signed word offset to the fetch stage.
REQ-010 id_valid, id_pc[7:0], id_opcode[3:0], id_rd[2:0], id_rs1_data[15:0], id_rs2_data[15:0], id_imm[15:0], id_reg_write, id_mem_read, id_mem_write  out  registered ID/EX bundle.

Function
REQ-011 Format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6; id_imm = sign-extended imm6.
REQ-012 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 JMP; 10-15 decode as NOP.
REQ-013 Control: reg_write for 1-6; mem_read for 6; mem_write for 7; all zero for NOP/BEQ/JMP/illegal.
REQ-014 IF/ID register (valid, pc, instruction) loads on every edge where instruction_fetch_en=1; holds otherwise.
REQ-015 Register file: 8x16; r0 reads 0, writes to r0 ignored; write on edge when wb_en=1.
REQ-016 Read bypass: rs equal to wb_addr (non-zero) with wb_en=1 returns wb_data same cycle.
REQ-017 Load-use hazard: IF/ID valid, ex_is_load=1, ex_rd!=0, ex_rd equals rs1, or rs2 for opcodes 1-4,7,8 -> stall=1.
REQ-018 Stall: instruction_fetch_en=0, IF/ID held, ID/EX loads bubble (id_valid=0, controls 0); lasts exactly while hazard holds.
REQ-019 Branch: combinational, IF/ID valid and no stall; BEQ taken when bypassed rs1 data == rs2 data; JMP always taken.
REQ-020 branch_offset_imm = imm6 of the IF/ID instruction when taken, 0 otherwise; target arithmetic (pc + sign-extended offset, mod 256) belongs to the fetch stage.
REQ-021 Flush: on edge with branch_taken=1, IF/ID loads valid=0 (wrong-path word discarded); ID/EX receives the branch with controls zero.
REQ-022 Latency: instruction captured edge k appears on ID/EX outputs after edge k+1.
REQ-023 Stall and branch never coincide (stall masks branch); wb write and read of same register same cycle follow REQ-016.

Reset
REQ-024 rst=1 clears IF/ID valid, all ID/EX outputs to 0, all registers r1-r7 to 0, immediately and independent of clock.
REQ-025 While rst=1 outputs: instruction_fetch_en=1, branch_taken=0, branch_offset_imm=0.
REQ-026 Reset mid-stall or mid-branch discards in-flight instruction; first post-reset edge loads IF/ID normally.

Structure
REQ-027 Shared package holds opcode enum, field bit positions, DATA_W/PC_W constants, ID/EX bundle struct.
REQ-028 One sub-module: id_regfile (8x16, 2 read ports with bypass, 1 write port, async reset).

Verification
REQ-029 Reset: rst pulse mid-run -> all id_* =0, instruction_fetch_en=1, r1-r7 read 0.
REQ-030 ADDI r1,r0,5 (0x5205) at pc 0x10 -> two edges later id_opcode=5, id_rd=1, id_imm=0x0005, id_reg_write=1, id_pc=0x10.
REQ-031 Load-use: ex_is_load=1, ex_rd=2, IF/ID ADD r3,r2,r1 -> instruction_fetch_en=0 one cycle, one bubble, ADD issued next cycle.
REQ-032 BEQ r1,r1 imm6=0x3E (-2) -> branch_taken=1, branch_offset_imm=0x3E, next IF/ID valid=0; with r1!=r2 BEQ -> branch_taken=0.
REQ-033 Bypass: wb_en=1, wb_addr=4, wb_data=0xBEEF same cycle as read of r4 -> id_rs1_data=0xBEEF; write to r0 -> r0 still reads 0.
REQ-034 Opcode 0xF -> decoded as NOP, all controls 0, id_valid=1.

Source files
------------

// File: rtl/id_stage_pkg.sv
//------------------------------------------------------------------------------
// id_stage_pkg : shared opcode, field and ID/EX bundle definitions
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package id_stage_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 8;

  localparam int c_op_hi  = 15;
  localparam int c_op_lo  = 12;
  localparam int c_rd_hi  = 11;
  localparam int c_rd_lo  = 9;
  localparam int c_rs1_hi = 8;
  localparam int c_rs1_lo = 6;
  localparam int c_rs2_hi = 5;
  localparam int c_rs2_lo = 3;
  localparam int c_imm_hi = 5;
  localparam int c_imm_lo = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_JMP  = 4'd9
  } opcode_e;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    opcode_e           opcode;
    logic [2:0]        rd;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } idex_t;

  // rs2 is a real operand only for these; elsewhere bits [5:3] belong to imm6
  function automatic logic uses_rs2(input opcode_e op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW, OP_BEQ});
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
//------------------------------------------------------------------------------
// id_regfile : 8x16 register file, r0 hardwired to zero, write-through reads
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  parameter int AW     = $clog2(REG_N)
) (
  input  logic              clk_ibuf,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] r_regs [REG_N];

  always_ff @(posedge clk_ibuf or posedge rst) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else if (wb_en && (wb_addr != '0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 :
                    (wb_en && (wb_addr == rs1_addr)) ? wb_data : r_regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 :
                    (wb_en && (wb_addr == rs2_addr)) ? wb_data : r_regs[rs2_addr];

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
//------------------------------------------------------------------------------
// id_stage : IF/ID register, decode, load-use stall, branch resolve, ID/EX reg
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int REG_N  = 8
) (
  input  logic              clk_ibuf,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruction,
  input  logic [PC_W-1:0]   pc,
  input  logic              ex_is_load,
  input  logic [2:0]        ex_rd,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              instruction_fetch_en,
  output logic              branch_taken,
  output logic [5:0]        branch_offset_imm,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [3:0]        id_opcode,
  output logic [2:0]        id_rd,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  output logic [DATA_W-1:0] id_imm,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write
);

  logic              r_ifid_valid;
  logic [PC_W-1:0]   r_ifid_pc;
  logic [DATA_W-1:0] r_ifid_instr;
  idex_t             r_idex;
  idex_t             w_idex_nxt;

  logic [3:0]        w_op_raw;
  opcode_e           w_op;
  logic [2:0]        w_rd;
  logic [2:0]        w_rs1;
  logic [2:0]        w_rs2;
  logic [5:0]        w_imm6;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic              w_stall;
  logic              w_branch;

  assign w_op_raw = r_ifid_instr[c_op_hi:c_op_lo];
  assign w_rd     = r_ifid_instr[c_rd_hi:c_rd_lo];
  assign w_rs1    = r_ifid_instr[c_rs1_hi:c_rs1_lo];
  assign w_rs2    = r_ifid_instr[c_rs2_hi:c_rs2_lo];
  assign w_imm6   = r_ifid_instr[c_imm_hi:c_imm_lo];
  assign w_op     = (w_op_raw <= 4'(OP_JMP)) ? opcode_e'(w_op_raw) : OP_NOP;

  id_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk_ibuf (clk_ibuf),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rs1_addr (w_rs1),
    .rs2_addr (w_rs2),
    .rs1_data (w_rs1_data),
    .rs2_data (w_rs2_data)
  );

  assign w_stall  = r_ifid_valid && ex_is_load && (ex_rd != 3'd0) &&
                    ((ex_rd == w_rs1) || (uses_rs2(w_op) && (ex_rd == w_rs2)));
  // A stalled branch is resolved later, once its operands are safe
  assign w_branch = r_ifid_valid && !w_stall &&
                    ((w_op == OP_JMP) || ((w_op == OP_BEQ) && (w_rs1_data == w_rs2_data)));

  assign instruction_fetch_en = !w_stall;
  assign branch_taken         = w_branch;
  assign branch_offset_imm    = w_branch ? w_imm6 : 6'd0;

  always_comb begin
    w_idex_nxt = '0;
    if (r_ifid_valid && !w_stall) begin
      w_idex_nxt.valid     = 1'b1;
      w_idex_nxt.pc        = r_ifid_pc;
      w_idex_nxt.opcode    = w_op;
      w_idex_nxt.rd        = w_rd;
      w_idex_nxt.rs1_data  = w_rs1_data;
      w_idex_nxt.rs2_data  = w_rs2_data;
      w_idex_nxt.imm       = {{(DATA_W-6){w_imm6[5]}}, w_imm6};
      w_idex_nxt.reg_write = (w_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW});
      w_idex_nxt.mem_read  = (w_op == OP_LW);
      w_idex_nxt.mem_write = (w_op == OP_SW);
    end
  end

  always_ff @(posedge clk_ibuf or posedge rst) begin
    if (rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else if (w_branch) begin
      r_ifid_valid <= 1'b0;
    end else if (!w_stall) begin
      r_ifid_valid <= 1'b1;
      r_ifid_pc    <= pc;
      r_ifid_instr <= instruction;
    end
  end

  always_ff @(posedge clk_ibuf or posedge rst) begin
    if (rst) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_idex_nxt;
    end
  end

  assign id_valid     = r_idex.valid;
  assign id_pc        = r_idex.pc;
  assign id_opcode    = r_idex.opcode;
  assign id_rd        = r_idex.rd;
  assign id_rs1_data  = r_idex.rs1_data;
  assign id_rs2_data  = r_idex.rs2_data;
  assign id_imm       = r_idex.imm;
  assign id_reg_write = r_idex.reg_write;
  assign id_mem_read  = r_idex.mem_read;
  assign id_mem_write = r_idex.mem_write;

endmodule

`default_nettype wire
